// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the hazard scheduler: RV32 major opcodes, the flush
// FSM state encoding and the canonical NOP instruction word.
package hazard_scheduler_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        StRun,
        StFlushing
    } state_e;

endpackage

// File: rtl/hazard_scheduler_if.sv
// Signal bundle between the decode/execute/writeback stages and the hazard
// scheduler.
//   master: the pipeline side, drives decode, writeback and jump events
//   slave : the scheduler, drives STALL/FLUSH/NEW_PC/ISSUE/PENDING
interface hazard_scheduler_if;

    logic        DEC_VALID;
    logic [16:0] DEC_OPCODE;  // {opcode[6:0], funct3, funct7}
    logic [4:0]  DEC_RD;
    logic [4:0]  DEC_RS1;
    logic [4:0]  DEC_RS2;
    logic        MMU_WAIT;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic        JUMP_REQ;
    logic [31:0] JUMP_PC;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] NEW_PC;
    logic        ISSUE;
    logic [31:0] PENDING;

    modport master (
        output DEC_VALID, DEC_OPCODE, DEC_RD, DEC_RS1, DEC_RS2, MMU_WAIT,
        output WB_VALID, WB_RD, JUMP_REQ, JUMP_PC,
        input  STALL, FLUSH, NEW_PC, ISSUE, PENDING
    );

    modport slave (
        input  DEC_VALID, DEC_OPCODE, DEC_RD, DEC_RS1, DEC_RS2, MMU_WAIT,
        input  WB_VALID, WB_RD, JUMP_REQ, JUMP_PC,
        output STALL, FLUSH, NEW_PC, ISSUE, PENDING
    );

endinterface

// File: rtl/hazard_scheduler_operand_usage.sv
// Decodes the major opcode into which register fields the instruction uses.
//   opcode_i  : DEC_OPCODE[16:10]
//   use_rs1_o : rs1 is read
//   use_rs2_o : rs2 is read
//   use_rd_o  : rd is written
module hazard_scheduler_operand_usage
    import hazard_scheduler_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       use_rs1_o,
    output logic       use_rs2_o,
    output logic       use_rd_o
);

    always_comb begin
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        use_rd_o  = 1'b0;
        case (opcode_i)
            OP: begin
                use_rs1_o = 1'b1;
                use_rs2_o = 1'b1;
                use_rd_o  = 1'b1;
            end
            OP_IMM, LOAD, JALR, SYSTEM: begin
                use_rs1_o = 1'b1;
                use_rd_o  = 1'b1;
            end
            STORE, BRANCH: begin
                use_rs1_o = 1'b1;
                use_rs2_o = 1'b1;
            end
            JAL, LUI, AUIPC: begin
                use_rd_o  = 1'b1;
            end
            default: ;  // unknown opcodes behave as NOPs
        endcase
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage pipeline controller: register-write scoreboard, in-flight
// write limiter and jump flush sequencer.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of hazard_scheduler_if (decode fields, MMU_WAIT,
//              writeback and jump events in; STALL, FLUSH, NEW_PC, ISSUE,
//              PENDING out)
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic               CLK,
    input logic               RST,
    hazard_scheduler_if.slave bus
);

    logic        use_rs1, use_rs2, use_rd;
    logic [31:0] pending_q, pending_d;
    logic [31:0] wb_mask, eff;
    logic [3:0]  inflight_q, inflight_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        issue_q;
    state_e      state_q, state_d;
    logic        run, hazard, issue, rd_write, wb_dec, inflight_full;
    logic        unused_funct;

    hazard_scheduler_operand_usage u_operand_usage (
        .opcode_i  (bus.DEC_OPCODE[16:10]),
        .use_rs1_o (use_rs1),
        .use_rs2_o (use_rs2),
        .use_rd_o  (use_rd)
    );

    // funct3/funct7 do not affect operand usage.
    assign unused_funct = ^bus.DEC_OPCODE[9:0];

    // Writeback in this cycle already resolves its register (write-through).
    always_comb begin
        wb_mask = '0;
        if (bus.WB_VALID) begin
            wb_mask[bus.WB_RD] = 1'b1;
        end
    end
    assign eff = pending_q & ~wb_mask;

    assign run           = (state_q == StRun);
    assign inflight_full = (inflight_q == 4'(MAX_INFLIGHT));
    assign hazard = (use_rs1 & eff[bus.DEC_RS1]) |
                    (use_rs2 & eff[bus.DEC_RS2]) |
                    (use_rd  & eff[bus.DEC_RD])  |
                    (use_rd  & (bus.DEC_RD != 5'd0) & inflight_full & ~bus.WB_VALID);
    assign issue    = bus.DEC_VALID & ~hazard & ~bus.MMU_WAIT & run & ~bus.JUMP_REQ;
    assign rd_write = issue & use_rd & (bus.DEC_RD != 5'd0);
    assign wb_dec   = bus.WB_VALID & (inflight_q != 4'd0);

    always_comb begin
        // Clear before set so a same-register race leaves the bit set.
        pending_d = pending_q & ~wb_mask;
        if (rd_write) begin
            pending_d[bus.DEC_RD] = 1'b1;
        end
        pending_d[0] = 1'b0;

        inflight_d = inflight_q;
        case ({rd_write, wb_dec})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = new_pc_q;
        if (bus.JUMP_REQ) begin
            // Applies in both states: the most recent jump wins.
            state_d  = StFlushing;
            cnt_d    = 3'(FLUSH_CYCLES - 1);
            new_pc_d = bus.JUMP_PC;
        end else if (state_q == StFlushing) begin
            if (cnt_q == 3'd0) begin
                state_d = StRun;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            new_pc_q   <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
            issue_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            new_pc_q   <= new_pc_d;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            issue_q    <= issue;
        end
    end

    assign bus.STALL   = bus.DEC_VALID & hazard & run;
    assign bus.FLUSH   = (state_q == StFlushing);
    assign bus.NEW_PC  = new_pc_q;
    assign bus.ISSUE   = issue_q;
    assign bus.PENDING = pending_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;

    hazard_scheduler_if bus ();

    hazard_scheduler #(
        .MAX_INFLIGHT (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait to mid-cycle to sample combinational outputs.
    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic dec(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
        bus.DEC_VALID  = v;
        bus.DEC_OPCODE = {op, 10'b0};
        bus.DEC_RD     = rd;
        bus.DEC_RS1    = rs1;
        bus.DEC_RS2    = rs2;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        bus.WB_VALID = v;
        bus.WB_RD    = rd;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST = 1'b1;
        dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b0, 5'd0);
        bus.MMU_WAIT = 1'b0;
        bus.JUMP_REQ = 1'b0;
        bus.JUMP_PC  = '0;

        // Reset then idle
        tick();
        tick();
        RST = 1'b0;
        chk("rst_stall", bus.STALL, 0);
        chk("rst_flush", bus.FLUSH, 0);
        chk("rst_new_pc", bus.NEW_PC, 0);
        chk("rst_issue", bus.ISSUE, 0);
        chk("rst_pending", bus.PENDING, 0);

        // RAW: add x5, x1, x2 then add x6, x5, x0
        dec(1'b1, OPC_OP, 5'd5, 5'd1, 5'd2);
        mid();
        chk("raw_first_nostall", bus.STALL, 0);
        tick();
        chk("raw_first_issue", bus.ISSUE, 1);
        chk("raw_first_pending", bus.PENDING, 32'h20);
        dec(1'b1, OPC_OP, 5'd6, 5'd5, 5'd0);
        mid();
        chk("raw_stall0", bus.STALL, 1);
        tick();
        chk("raw_noissue", bus.ISSUE, 0);
        mid();
        chk("raw_stall1", bus.STALL, 1);
        tick();
        wb(1'b1, 5'd5);
        mid();
        chk("raw_wb_bypass", bus.STALL, 0);
        tick();
        chk("raw_issue_after_wb", bus.ISSUE, 1);
        chk("raw_pending_swap", bus.PENDING, 32'h40);
        dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd6);
        tick();
        wb(1'b0, 5'd0);
        chk("raw_drained", bus.PENDING, 0);

        // x0 destination never pending
        dec(1'b1, OPC_OP_IMM, 5'd0, 5'd0, 5'd0);
        tick();
        chk("x0_issue", bus.ISSUE, 1);
        chk("x0_pending", bus.PENDING, 0);

        // Set/clear race on x7
        dec(1'b1, OPC_OP_IMM, 5'd7, 5'd0, 5'd0);
        tick();
        chk("race_pre_pending", bus.PENDING, 32'h80);
        wb(1'b1, 5'd7);
        mid();
        chk("race_nostall", bus.STALL, 0);
        tick();
        chk("race_issue", bus.ISSUE, 1);
        chk("race_set_wins", bus.PENDING, 32'h80);
        dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        wb(1'b0, 5'd0);
        chk("race_drained", bus.PENDING, 0);

        // In-flight limit: x1..x4 then x6
        for (int r = 1; r <= 4; r++) begin
            dec(1'b1, OPC_OP_IMM, 5'(r), 5'd0, 5'd0);
            tick();
        end
        chk("limit_pending4", bus.PENDING, 32'h1E);
        dec(1'b1, OPC_OP_IMM, 5'd6, 5'd0, 5'd0);
        mid();
        chk("limit_stall", bus.STALL, 1);
        tick();
        chk("limit_noissue", bus.ISSUE, 0);
        wb(1'b1, 5'd1);
        mid();
        chk("limit_wb_release", bus.STALL, 0);
        tick();
        chk("limit_issue", bus.ISSUE, 1);
        chk("limit_pending", bus.PENDING, 32'h5C);
        dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd2);
        tick();
        wb(1'b1, 5'd3);
        tick();
        wb(1'b1, 5'd4);
        tick();
        wb(1'b1, 5'd6);
        tick();
        wb(1'b0, 5'd0);
        chk("limit_drained", bus.PENDING, 0);

        // Flush for two cycles, decode held valid throughout
        dec(1'b1, OPC_OP_IMM, 5'd0, 5'd0, 5'd0);
        bus.JUMP_REQ = 1'b1;
        bus.JUMP_PC  = 32'h100;
        mid();
        chk("jump_cycle_flush", bus.FLUSH, 0);
        tick();
        bus.JUMP_REQ = 1'b0;
        chk("flush1", bus.FLUSH, 1);
        chk("flush1_pc", bus.NEW_PC, 32'h100);
        chk("flush1_noissue", bus.ISSUE, 0);
        mid();
        chk("flush1_nostall", bus.STALL, 0);
        tick();
        chk("flush2", bus.FLUSH, 1);
        chk("flush2_pc", bus.NEW_PC, 32'h100);
        chk("flush2_noissue", bus.ISSUE, 0);
        tick();
        chk("flush_end", bus.FLUSH, 0);
        chk("flush_end_noissue", bus.ISSUE, 0);
        tick();
        chk("flush_resume_issue", bus.ISSUE, 1);
        dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);

        // Second jump during flush cycle 1 extends and retargets
        bus.JUMP_REQ = 1'b1;
        bus.JUMP_PC  = 32'h100;
        tick();
        chk("rejump_flush1", bus.FLUSH, 1);
        bus.JUMP_PC = 32'h200;
        tick();
        bus.JUMP_REQ = 1'b0;
        chk("rejump_flush2", bus.FLUSH, 1);
        chk("rejump_pc", bus.NEW_PC, 32'h200);
        tick();
        chk("rejump_flush3", bus.FLUSH, 1);
        chk("rejump_pc3", bus.NEW_PC, 32'h200);
        tick();
        chk("rejump_end", bus.FLUSH, 0);

        // MMU_WAIT blocks issue without stalling
        dec(1'b1, OPC_OP_IMM, 5'd9, 5'd0, 5'd0);
        bus.MMU_WAIT = 1'b1;
        mid();
        chk("mmu_nostall", bus.STALL, 0);
        tick();
        chk("mmu_noissue", bus.ISSUE, 0);
        chk("mmu_pending", bus.PENDING, 0);
        bus.MMU_WAIT = 1'b0;

        // Reset in the middle of a flush with a pending register
        tick();
        dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        chk("pre_rst_pending", bus.PENDING, 32'h200);
        bus.JUMP_REQ = 1'b1;
        bus.JUMP_PC  = 32'h300;
        tick();
        bus.JUMP_REQ = 1'b0;
        chk("pre_rst_flush", bus.FLUSH, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_stall", bus.STALL, 0);
        chk("mid_rst_flush", bus.FLUSH, 0);
        chk("mid_rst_new_pc", bus.NEW_PC, 0);
        chk("mid_rst_issue", bus.ISSUE, 0);
        chk("mid_rst_pending", bus.PENDING, 0);
        tick();
        chk("post_rst_flush", bus.FLUSH, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
